sgmii_an_rx_parser: RTL

- Receive-side parser for SGMII auto-negotiation ordered sets.
- Sits directly downstream of the 8b/10b decoder in the SGMII receive path.
- Consumes the decoded byte stream and detects /C1/ and /C2/ configuration sets and /I1/ and /I2/ idle sets.
- Extracts the 16-bit rx config register and produces ability_match, ack_match and idle_match for the auto-negotiation arbitration FSM.
- This is the block that consumes the config stream generated by send_an_flp and send_an_ord stimulus.

---
 rtl/sgmii_an_rx_parser.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sgmii_an_rx_parser.sv
// SGMII auto-negotiation receive parser: detects /C1/,/C2/,/I1/,/I2/ ordered sets in the
// decoded code-group stream and produces the config word and match flags for the AN arbiter.
module sgmii_an_rx_parser #(
  parameter int MATCH_COUNT = 3,
  parameter int ACK_BIT     = 14
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_is_k,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [15:0] cfg_word,
  output logic        cfg_valid,
  output logic        ability_match,
  output logic        ack_match,
  output logic        idle_match,
  output logic        rx_config_active
);

  typedef enum logic [1:0] {HUNT, SEL, CFG_LO, CFG_HI} state_t;

  localparam logic [3:0]  MC       = 4'(MATCH_COUNT);
  localparam logic [15:0] ACK_MASK = ~(16'd1 << ACK_BIT);

  state_t      state, state_nxt;
  logic [7:0]  lo_byte;
  logic [15:0] prev_word;
  logic        prev_valid;
  logic [3:0]  abl_cnt, ack_cnt, idle_cnt;

  logic        is_comma, is_cfg_sel, is_idle_sel;
  logic        abort, lo_load, cfg_done, idle_done;
  logic [15:0] word;
  logic        same_word;
  logic [3:0]  abl_inc, ack_inc, idle_inc, abl_new, ack_new;
  logic        cfg_pulse;

  assign is_comma    = rx_is_k && (rx_data == 8'hBC);
  assign is_cfg_sel  = !rx_is_k && ((rx_data == 8'hB5) || (rx_data == 8'h42));
  assign is_idle_sel = !rx_is_k && ((rx_data == 8'hC5) || (rx_data == 8'h50));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= HUNT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rx_valid) begin
      if (abort) begin
        state_nxt = HUNT;
      end else begin
        case (state)
          HUNT:    if (is_comma) state_nxt = SEL;
          SEL: begin
            if (is_comma)        state_nxt = SEL;
            else if (is_cfg_sel) state_nxt = CFG_LO;
            else                 state_nxt = HUNT;
          end
          CFG_LO:  state_nxt = CFG_HI;
          CFG_HI:  state_nxt = HUNT;
          default: state_nxt = HUNT;
        endcase
      end
    end
  end

  always_comb begin
    abort     = rx_valid && (rx_err || (rx_is_k && ((state == CFG_LO) || (state == CFG_HI))));
    lo_load   = rx_valid && !abort && (state == CFG_LO);
    cfg_done  = rx_valid && !abort && (state == CFG_HI);
    idle_done = rx_valid && !abort && (state == SEL) && is_idle_sel;
  end

  // Counter arithmetic for a completing set; the ACK bit is ignored when comparing words.
  always_comb begin
    word      = {rx_data, lo_byte};
    same_word = prev_valid && ((word & ACK_MASK) == (prev_word & ACK_MASK));
    abl_inc   = (abl_cnt  == MC) ? MC : abl_cnt  + 4'd1;
    ack_inc   = (ack_cnt  == MC) ? MC : ack_cnt  + 4'd1;
    idle_inc  = (idle_cnt == MC) ? MC : idle_cnt + 4'd1;
    abl_new   = same_word ? abl_inc : 4'd1;
    if (same_word && word[ACK_BIT]) ack_new = ack_inc;
    else                            ack_new = word[ACK_BIT] ? 4'd1 : 4'd0;
    cfg_pulse = (abl_new == MC) && !(same_word && (abl_cnt == MC));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lo_byte          <= '0;
      prev_word        <= '0;
      prev_valid       <= 1'b0;
      abl_cnt          <= '0;
      ack_cnt          <= '0;
      idle_cnt         <= '0;
      cfg_word         <= '0;
      cfg_valid        <= 1'b0;
      ability_match    <= 1'b0;
      ack_match        <= 1'b0;
      idle_match       <= 1'b0;
      rx_config_active <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      if (abort) begin
        abl_cnt       <= '0;
        ack_cnt       <= '0;
        idle_cnt      <= '0;
        prev_valid    <= 1'b0;
        ability_match <= 1'b0;
        ack_match     <= 1'b0;
        idle_match    <= 1'b0;
      end else if (lo_load) begin
        lo_byte <= rx_data;
      end else if (cfg_done) begin
        idle_cnt         <= '0;
        idle_match       <= 1'b0;
        rx_config_active <= 1'b1;
        abl_cnt          <= abl_new;
        ack_cnt          <= ack_new;
        prev_word        <= word;
        prev_valid       <= 1'b1;
        ability_match    <= (abl_new == MC);
        ack_match        <= (abl_new == MC) && (ack_new == MC);
        cfg_valid        <= cfg_pulse;
        // While matched, an ACK-only change refreshes cfg_word without a new pulse.
        if (abl_new == MC) cfg_word <= word;
      end else if (idle_done) begin
        idle_cnt         <= idle_inc;
        idle_match       <= (idle_inc == MC);
        abl_cnt          <= '0;
        ack_cnt          <= '0;
        ability_match    <= 1'b0;
        ack_match        <= 1'b0;
        rx_config_active <= 1'b0;
      end
    end
  end

endmodule
